// File: rtl/v_pkg.sv
// Shared widths and state encoding for the vector memory stage.
package v_pkg;

  localparam int unsigned V_VREG_DW = 512;
  localparam int unsigned V_MEM_DW  = 64;
  localparam int unsigned V_MEM_AW  = 32;
  localparam int unsigned V_BEATS   = V_VREG_DW / V_MEM_DW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/v_mem_access.sv
// Vector memory stage: moves one vector register to/from data RAM as a
// sequence of single-outstanding bus beats, stalling the pipeline meanwhile.
module v_mem_access
  import v_pkg::*;
#(
  parameter int unsigned VREG_DW = V_VREG_DW,
  parameter int unsigned MEM_DW  = V_MEM_DW,
  parameter int unsigned MEM_AW  = V_MEM_AW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vid_mem_ren_i,
  input  logic               vid_mem_wen_i,
  input  logic [MEM_AW-1:0]  vid_mem_addr_i,
  input  logic [VREG_DW-1:0] vid_mem_wdata_i,
  output logic               vmem_stall_o,
  output logic               vmem_valid_o,
  output logic [VREG_DW-1:0] vmem_result_o,
  output logic               vram_req_o,
  output logic               vram_we_o,
  output logic [MEM_AW-1:0]  vram_addr_o,
  output logic [MEM_DW-1:0]  vram_wdata_o,
  input  logic               vram_gnt_i,
  input  logic               vram_rvalid_i,
  input  logic [MEM_DW-1:0]  vram_rdata_i
);

  localparam int unsigned BEATS  = VREG_DW / MEM_DW;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned BYTES  = MEM_DW / 8;
  localparam int unsigned OFF_W  = (BYTES > 1) ? $clog2(BYTES) : 1;

  state_t              state, state_nx;
  logic [BEAT_W-1:0]   beat, beat_nx;
  logic                op_we;
  logic [MEM_AW-1:0]   base_q;
  logic [VREG_DW-1:0]  wdata_q;
  logic [VREG_DW-1:0]  result_q;
  logic                capture, shift, rd_wr, last;

  assign last = (beat == BEAT_W'(BEATS - 1));

  // State, captured command and result storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      beat     <= '0;
      op_we    <= 1'b0;
      base_q   <= '0;
      wdata_q  <= '0;
      result_q <= '0;
    end else begin
      state <= state_nx;
      beat  <= beat_nx;
      if (capture) begin
        op_we   <= vid_mem_wen_i;
        base_q  <= vid_mem_addr_i & ~MEM_AW'(BYTES - 1);
        wdata_q <= vid_mem_wdata_i;
      end else if (shift) begin
        // Store data is consumed from the bottom, one bus word per granted beat.
        wdata_q <= wdata_q >> MEM_DW;
      end
      if (rd_wr) begin
        for (int k = 0; k < int'(BEATS); k++) begin
          if (beat == BEAT_W'(k)) result_q[k*MEM_DW +: MEM_DW] <= vram_rdata_i;
        end
      end
    end
  end

  // Next state and outputs.
  always_comb begin
    state_nx     = state;
    beat_nx      = beat;
    capture      = 1'b0;
    shift        = 1'b0;
    rd_wr        = 1'b0;
    vmem_stall_o = 1'b0;
    vmem_valid_o = 1'b0;
    vram_req_o   = 1'b0;
    case (state)
      IDLE: begin
        if (vid_mem_ren_i || vid_mem_wen_i) begin
          capture      = 1'b1;
          vmem_stall_o = 1'b1;
          beat_nx      = '0;
          state_nx     = REQ;
        end
      end
      REQ: begin
        vmem_stall_o = 1'b1;
        vram_req_o   = 1'b1;
        if (vram_gnt_i) begin
          if (!op_we) begin
            state_nx = WAIT;
          end else begin
            shift = 1'b1;
            if (last) state_nx = DONE;
            else      beat_nx  = beat + BEAT_W'(1);
          end
        end
      end
      WAIT: begin
        vmem_stall_o = 1'b1;
        if (vram_rvalid_i) begin
          rd_wr = 1'b1;
          if (last) begin
            state_nx = DONE;
          end else begin
            beat_nx  = beat + BEAT_W'(1);
            state_nx = REQ;
          end
        end
      end
      DONE: begin
        vmem_valid_o = 1'b1;
        state_nx     = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign vram_we_o     = vram_req_o & op_we;
  assign vram_addr_o   = vram_req_o ? (base_q + (MEM_AW'(beat) << OFF_W)) : '0;
  assign vram_wdata_o  = vram_we_o ? wdata_q[MEM_DW-1:0] : '0;
  assign vmem_result_o = result_q;

endmodule

// File: tb/tb_v_mem_access.sv
// Scoreboard bench for v_mem_access: stimulus pushes expected beats and
// completions, a negedge monitor pops and compares, a bus slave model responds.
module tb_v_mem_access;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ren = 1'b0, wen = 1'b0;
  logic [31:0]  cmd_addr = '0;
  logic [511:0] cmd_wdata = '0;
  logic         stall, valid;
  logic [511:0] result;
  logic         req, we;
  logic [31:0]  baddr;
  logic [63:0]  bwdata;
  logic         gnt = 1'b0, rvalid = 1'b0;
  logic [63:0]  rdata = '0;

  v_mem_access dut (
    .clk(clk), .rst(rst),
    .vid_mem_ren_i(ren), .vid_mem_wen_i(wen),
    .vid_mem_addr_i(cmd_addr), .vid_mem_wdata_i(cmd_wdata),
    .vmem_stall_o(stall), .vmem_valid_o(valid), .vmem_result_o(result),
    .vram_req_o(req), .vram_we_o(we), .vram_addr_o(baddr), .vram_wdata_o(bwdata),
    .vram_gnt_i(gnt), .vram_rvalid_i(rvalid), .vram_rdata_i(rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [63:0] wdata;
  } beat_t;

  typedef struct {
    logic [511:0] res;
    int           cmd_cyc;
    int           due_cyc;
  } done_t;

  beat_t        beat_q[$];
  done_t        done_q[$];
  int           cyc = 0;
  int           n_tests = 0;
  int           n_fail = 0;
  logic [511:0] exp_result = '0;

  // Slave configuration
  logic [63:0]  rd_base = '0;
  int           g_beat = -1, g_dly = 0, r_beat = -1, r_dly = 0;
  bit           spur = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Bus slave: grants and returns read data, with optional per-beat delays.
  initial begin : slave
    int  sbeat;
    int  gcnt;
    int  rcnt;
    bit  pending;
    sbeat = 0; gcnt = 0; rcnt = 0; pending = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      gnt = 1'b0; rvalid = 1'b0; rdata = '0;
      if (rst) begin
        sbeat = 0; gcnt = 0; rcnt = 0; pending = 1'b0;
      end else begin
        if (valid) sbeat = 0;
        if (pending) begin
          if (sbeat == r_beat && rcnt < r_dly) begin
            rcnt++;
          end else begin
            rvalid = 1'b1; rdata = rd_base + 64'(sbeat);
            pending = 1'b0; rcnt = 0; sbeat++;
          end
        end else if (req) begin
          if (sbeat == g_beat && gcnt < g_dly) begin
            gcnt++;
          end else begin
            gnt = 1'b1; gcnt = 0;
            if (we) sbeat++;
            else    pending = 1'b1;
          end
        end else if (spur) begin
          gnt = 1'b1; rvalid = 1'b1; rdata = 64'hDEAD_BEEF_0BAD_F00D;
        end
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a beat or a completion.
  initial begin : monitor
    int          stall_run;
    bit          prev_hold;
    logic [31:0] prev_addr;
    logic [63:0] prev_wdata;
    beat_t       b;
    done_t       d;
    stall_run = 0; prev_hold = 1'b0; prev_addr = '0; prev_wdata = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_run = 0; prev_hold = 1'b0;
      end else begin
        if (prev_hold) begin
          chk("hold_req", 512'(req), 512'(1));
          chk("hold_addr", 512'(baddr), 512'(prev_addr));
          chk("hold_wdata", 512'(bwdata), 512'(prev_wdata));
        end
        if (req && gnt) begin
          if (beat_q.size() == 0) begin
            chk("beat_unexpected", 512'(baddr), 512'(0));
          end else begin
            b = beat_q.pop_front();
            chk("beat_we", 512'(we), 512'(b.we));
            chk("beat_addr", 512'(baddr), 512'(b.addr));
            if (b.we) chk("beat_wdata", 512'(bwdata), 512'(b.wdata));
          end
        end
        prev_hold  = req && !gnt;
        prev_addr  = baddr;
        prev_wdata = bwdata;
        if (valid) begin
          if (done_q.size() == 0) begin
            chk("valid_unexpected", 512'(valid), 512'(0));
          end else begin
            d = done_q.pop_front();
            chk("valid_cycle", 512'(cyc), 512'(d.due_cyc));
            chk("result", result, d.res);
            chk("stall_len", 512'(stall_run), 512'(d.due_cyc - d.cmd_cyc));
            chk("stall_in_done", 512'(stall), 512'(0));
          end
        end
        stall_run = stall ? stall_run + 1 : 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic clear_cmd();
    ren = 1'b0; wen = 1'b0;
  endtask

  task automatic issue(input bit is_st, input bit both, input logic [31:0] base,
                       input logic [511:0] wd, input int nb, input int extra,
                       input bit push_done, output int due);
    logic [31:0] al;
    beat_t       b;
    done_t       d;
    al = base & 32'hFFFF_FFF8;
    for (int k = 0; k < nb; k++) begin
      b.we    = is_st;
      b.addr  = al + 32'(k * 8);
      b.wdata = wd[k*64 +: 64];
      beat_q.push_back(b);
    end
    if (!is_st)
      for (int k = 0; k < 8; k++) exp_result[k*64 +: 64] = rd_base + 64'(k);
    due = cyc + (is_st ? 9 : 17) + extra;
    if (push_done) begin
      d.res = exp_result; d.cmd_cyc = cyc; d.due_cyc = due;
      done_q.push_back(d);
    end
    ren = !is_st || both;
    wen = is_st;
    cmd_addr  = base;
    cmd_wdata = wd;
  endtask

  function automatic logic [511:0] lanes(input logic [63:0] b0);
    logic [511:0] v;
    for (int k = 0; k < 8; k++) v[k*64 +: 64] = b0 + 64'(k);
    return v;
  endfunction

  initial begin : stim
    int due;
    int c;
    repeat (3) step();
    rst = 1'b0;
    #1;
    chk("rst_stall", 512'(stall), 512'(0));
    chk("rst_valid", 512'(valid), 512'(0));
    chk("rst_req", 512'(req), 512'(0));
    chk("rst_bus", 512'({we, baddr, bwdata}), 512'(0));
    chk("rst_result", result, 512'(0));
    step();

    // 1: plain load
    rd_base = 64'h0;
    issue(1'b0, 1'b0, 32'h100, '0, 8, 0, 1'b1, due);
    step(); clear_cmd(); wait_until(due + 1);

    // 2: store at misaligned base
    issue(1'b1, 1'b0, 32'h207, lanes(64'hA0), 8, 0, 1'b1, due);
    step(); clear_cmd(); wait_until(due + 1);

    // 3: load with delayed grant on beat 2 and delayed rvalid on beat 5
    rd_base = 64'h1000; g_beat = 2; g_dly = 3; r_beat = 5; r_dly = 2;
    issue(1'b0, 1'b0, 32'h300, '0, 8, 5, 1'b1, due);
    step(); clear_cmd(); wait_until(due + 1);
    g_beat = -1; r_beat = -1;

    // 4: address wrap
    rd_base = 64'h2000;
    issue(1'b0, 1'b0, 32'hFFFF_FFF0, '0, 8, 0, 1'b1, due);
    step(); clear_cmd(); wait_until(due + 1);

    // 5: reset during WAIT of beat 4
    rd_base = 64'h3000;
    c = cyc;
    issue(1'b0, 1'b0, 32'h400, '0, 5, 0, 1'b0, due);
    step(); clear_cmd(); wait_until(c + 10);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_result = '0;
    chk("abort_req", 512'(req), 512'(0));
    chk("abort_stall", 512'(stall), 512'(0));
    chk("abort_valid", 512'(valid), 512'(0));
    chk("abort_result", result, 512'(0));
    step();
    rd_base = 64'h4000;
    issue(1'b0, 1'b0, 32'h80, '0, 8, 0, 1'b1, due);
    step(); clear_cmd(); wait_until(due + 1);

    // 6: ren+wen held through DONE, then a load right after, with spurious bus inputs
    spur = 1'b1;
    step();
    issue(1'b1, 1'b1, 32'h500, lanes(64'h50), 8, 0, 1'b1, due);
    wait_until(due + 1);
    rd_base = 64'h5000;
    issue(1'b0, 1'b0, 32'h600, '0, 8, 0, 1'b1, due);
    step(); clear_cmd(); wait_until(due + 1);
    repeat (4) step();
    chk("result_after_spur", result, exp_result);
    spur = 1'b0;
    repeat (2) step();

    chk("beats_left", 512'(beat_q.size()), 512'(0));
    chk("dones_left", 512'(done_q.size()), 512'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
